// File: rtl/lockstep_stream_cmp_pkg.sv
// Shared types for the lockstep stream comparator: state encoding,
// error codes and the lead indicator encoding.
package lockstep_cmp_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'b00,
      A_AHEAD = 2'b01,
      B_AHEAD = 2'b10,
      ERROR   = 2'b11
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISMATCH = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   localparam logic [1:0] LEAD_NONE = 2'b00;
   localparam logic [1:0] LEAD_A    = 2'b01;
   localparam logic [1:0] LEAD_B    = 2'b10;

endpackage

// File: rtl/lockstep_stream_cmp_fifo.sv
// Skew buffer for the leading stream. Push and pop may coincide even when
// full; a pop in that cycle still sees the old head.
module cmp_fifo #(
   parameter int DATA_W = 36,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    push,
   input  logic [DATA_W-1:0]       push_data,
   input  logic                    pop,
   output logic [DATA_W-1:0]       head,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     count_q, count_d;

   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + PTR_W'(1);
      end else begin
         wr_d = wr_q;
      end
      if (pop) begin
         rd_d = rd_q + PTR_W'(1);
      end else begin
         rd_d = rd_q;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign count = count_q;

endmodule

// File: rtl/lockstep_stream_cmp.sv
// Lockstep checker for two redundant in-order streams. The leading side is
// buffered and matched in order; the first fault is latched with diagnostics.
module lockstep_stream_cmp
   import lockstep_cmp_pkg::*;
#(
   parameter int DATA_W  = 36,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    a_valid,
   input  logic [DATA_W-1:0]       a_data,
   input  logic                    b_valid,
   input  logic [DATA_W-1:0]       b_data,
   output logic [1:0]              lead,
   output logic [$clog2(DEPTH):0]  pending,
   output logic                    err,
   output logic [1:0]              err_code,
   output logic [DATA_W-1:0]       err_data_a,
   output logic [DATA_W-1:0]       err_data_b,
   output logic [CNT_W-1:0]        match_count
);
   localparam int             CW       = $clog2(DEPTH) + 1;
   localparam int             TMO_W    = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 1;
   localparam bit             TMO_EN   = (TIMEOUT > 32'sd0);
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   state_e             state_q, state_d;
   logic [1:0]         lead_q, lead_d, err_code_q, err_code_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  err_a_q, err_a_d, err_b_q, err_b_d;
   logic [CNT_W-1:0]   match_q, match_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;

   logic               fifo_push_s, fifo_pop_s;
   logic [DATA_W-1:0]  fifo_wdata_s, fifo_head_s;
   logic [CW-1:0]      fifo_count_s, next_cnt_s;
   logic               a_lead_s, lead_valid_s, trail_valid_s;
   logic [DATA_W-1:0]  lead_data_s, trail_data_s, other_slot_s;
   logic [DATA_W-1:0]  cmp_a_s, cmp_b_s;
   logic               push_req_s, pop_req_s, match_s, mis_s, ovf_s, tmo_hit_s, err_any_s;

   cmp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (fifo_push_s),
      .push_data (fifo_wdata_s),
      .pop       (fifo_pop_s),
      .head      (fifo_head_s),
      .count     (fifo_count_s)
   );

   // Event detection: map A/B onto leading/trailing roles, find compares and faults.
   always_comb begin
      a_lead_s      = (state_q == A_AHEAD);
      lead_valid_s  = a_lead_s ? a_valid : b_valid;
      lead_data_s   = a_lead_s ? a_data  : b_data;
      trail_valid_s = a_lead_s ? b_valid : a_valid;
      trail_data_s  = a_lead_s ? b_data  : a_data;
      push_req_s    = 1'b0;
      pop_req_s     = 1'b0;
      match_s       = 1'b0;
      mis_s         = 1'b0;
      ovf_s         = 1'b0;
      tmo_hit_s     = 1'b0;
      other_slot_s  = '0;
      fifo_wdata_s  = lead_data_s;
      cmp_a_s       = a_data;
      cmp_b_s       = b_data;
      case (state_q)
         EMPTY: begin
            fifo_wdata_s = a_valid ? a_data : b_data;
            if (a_valid && b_valid) begin
               match_s = (a_data == b_data);
               mis_s   = (a_data != b_data);
            end else begin
               push_req_s = a_valid || b_valid;
            end
         end
         A_AHEAD, B_AHEAD: begin
            pop_req_s  = trail_valid_s;
            push_req_s = lead_valid_s;
            match_s    = trail_valid_s && (fifo_head_s == trail_data_s);
            mis_s      = trail_valid_s && (fifo_head_s != trail_data_s);
            ovf_s      = lead_valid_s && !trail_valid_s && (fifo_count_s == FULL_CNT);
            tmo_hit_s  = TMO_EN && !trail_valid_s && (fifo_count_s != '0)
                         && (tmo_q == TMO_W'(TIMEOUT - 1));
            // The head always reports in the leading side's slot.
            if (mis_s) begin
               other_slot_s = trail_data_s;
            end else if (ovf_s) begin
               other_slot_s = lead_data_s;
            end else begin
               other_slot_s = '0;
            end
            cmp_a_s = a_lead_s ? fifo_head_s  : other_slot_s;
            cmp_b_s = a_lead_s ? other_slot_s : fifo_head_s;
         end
         default: begin
            push_req_s = 1'b0;
         end
      endcase
      err_any_s   = mis_s || ovf_s || tmo_hit_s;
      fifo_push_s = push_req_s && !err_any_s;
      fifo_pop_s  = pop_req_s && !err_any_s;
      next_cnt_s  = fifo_count_s + CW'(fifo_push_s) - CW'(fifo_pop_s);
   end

   // Next-state, error capture, match counting and stall timer.
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      err_a_d    = err_a_q;
      err_b_d    = err_b_q;
      match_d    = match_q;
      tmo_d      = tmo_q;
      if (state_q == ERROR) begin
         state_d = ERROR;
      end else if (err_any_s) begin
         state_d    = ERROR;
         err_d      = 1'b1;
         err_code_d = mis_s ? ERR_MISMATCH : (ovf_s ? ERR_OVERFLOW : ERR_TIMEOUT);
         err_a_d    = cmp_a_s;
         err_b_d    = cmp_b_s;
      end else begin
         if (match_s && (match_q != '1)) begin
            match_d = match_q + CNT_W'(1);
         end else begin
            match_d = match_q;
         end
         if (TMO_EN && (fifo_count_s != '0) && !fifo_pop_s) begin
            tmo_d = tmo_q + TMO_W'(1);
         end else begin
            tmo_d = '0;
         end
         case (state_q)
            EMPTY: begin
               if (a_valid && !b_valid) begin
                  state_d = A_AHEAD;
               end else if (b_valid && !a_valid) begin
                  state_d = B_AHEAD;
               end else begin
                  state_d = EMPTY;
               end
            end
            A_AHEAD, B_AHEAD: begin
               if (next_cnt_s == '0) begin
                  state_d = EMPTY;
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // Lead indicator tracks the next state; it holds its last value in ERROR.
   always_comb begin
      case (state_d)
         EMPTY:   lead_d = LEAD_NONE;
         A_AHEAD: lead_d = LEAD_A;
         B_AHEAD: lead_d = LEAD_B;
         default: lead_d = lead_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= EMPTY;
         lead_q     <= LEAD_NONE;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         err_a_q    <= '0;
         err_b_q    <= '0;
         match_q    <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         lead_q     <= lead_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_a_q    <= err_a_d;
         err_b_q    <= err_b_d;
         match_q    <= match_d;
         tmo_q      <= tmo_d;
      end
   end

   assign lead        = lead_q;
   assign pending     = fifo_count_s;
   assign err         = err_q;
   assign err_code    = err_code_q;
   assign err_data_a  = err_a_q;
   assign err_data_b  = err_b_q;
   assign match_count = match_q;

endmodule

// File: tb/tb_lockstep_stream_cmp.sv
// Directed bench for lockstep_stream_cmp; a second narrow-counter instance
// shares the stimulus to exercise match_count saturation.
module tb_lockstep_stream_cmp;
   localparam int DATA_W  = 36;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 32;
   localparam int PW      = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              a_valid = 1'b0, b_valid = 1'b0;
   logic [DATA_W-1:0] a_data = '0, b_data = '0;

   logic [1:0]        lead, err_code;
   logic [PW-1:0]     pending;
   logic              err;
   logic [DATA_W-1:0] err_data_a, err_data_b;
   logic [CNT_W-1:0]  match_count;

   logic [1:0]        sat_lead, sat_err_code;
   logic [PW-1:0]     sat_pending;
   logic              sat_err;
   logic [DATA_W-1:0] sat_err_data_a, sat_err_data_b;
   logic [1:0]        sat_match_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lockstep_stream_cmp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
      .lead(lead), .pending(pending), .err(err), .err_code(err_code),
      .err_data_a(err_data_a), .err_data_b(err_data_b), .match_count(match_count)
   );

   lockstep_stream_cmp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(2)) dut_sat (
      .clk(clk), .resetn(resetn),
      .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
      .lead(sat_lead), .pending(sat_pending), .err(sat_err), .err_code(sat_err_code),
      .err_data_a(sat_err_data_a), .err_data_b(sat_err_data_b), .match_count(sat_match_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic av, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [DATA_W-1:0] bd);
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
      @(posedge clk);
      #1;
      a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 36'h0, 1'b0, 36'h0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_lead"},    64'(lead), 64'h0);
      check_eq({tag, "_pending"}, 64'(pending), 64'h0);
      check_eq({tag, "_err"},     64'(err), 64'h0);
      check_eq({tag, "_code"},    64'(err_code), 64'h0);
      check_eq({tag, "_da"},      64'(err_data_a), 64'h0);
      check_eq({tag, "_db"},      64'(err_data_b), 64'h0);
      check_eq({tag, "_match"},   64'(match_count), 64'h0);
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      idle(1);
      resetn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset state
      idle(2);
      check_all_zero("reset");
      resetn = 1'b1;

      // Lockstep: no skew
      step(1'b1, 36'h1, 1'b1, 36'h1);
      check_eq("ls_lead1", 64'(lead), 64'h0);
      check_eq("ls_pend1", 64'(pending), 64'h0);
      step(1'b1, 36'h2, 1'b1, 36'h2);
      step(1'b1, 36'h3, 1'b1, 36'h3);
      check_eq("ls_lead3", 64'(lead), 64'h0);
      check_eq("ls_match", 64'(match_count), 64'd3);
      check_eq("ls_err", 64'(err), 64'h0);

      // Skew: A two cycles ahead
      step(1'b1, 36'hA, 1'b0, 36'h0);
      check_eq("sk_pend1", 64'(pending), 64'd1);
      check_eq("sk_lead1", 64'(lead), 64'h1);
      step(1'b1, 36'hB, 1'b0, 36'h0);
      check_eq("sk_pend2", 64'(pending), 64'd2);
      step(1'b0, 36'h0, 1'b1, 36'hA);
      check_eq("sk_pend3", 64'(pending), 64'd1);
      check_eq("sk_lead3", 64'(lead), 64'h1);
      step(1'b0, 36'h0, 1'b1, 36'hB);
      check_eq("sk_pend4", 64'(pending), 64'd0);
      check_eq("sk_lead4", 64'(lead), 64'h0);
      check_eq("sk_match", 64'(match_count), 64'd5);
      check_eq("sat_match", 64'(sat_match_count), 64'd3);

      // B ahead mirror
      step(1'b0, 36'h0, 1'b1, 36'h7);
      check_eq("bk_lead", 64'(lead), 64'h2);
      check_eq("bk_pend", 64'(pending), 64'd1);
      step(1'b1, 36'h7, 1'b0, 36'h0);
      check_eq("bk_lead2", 64'(lead), 64'h0);
      check_eq("bk_match", 64'(match_count), 64'd6);
      check_eq("sat_hold", 64'(sat_match_count), 64'd3);

      // Mismatch under skew, then inputs ignored
      step(1'b1, 36'h5, 1'b0, 36'h0);
      idle(1);
      check_eq("mm_pre_err", 64'(err), 64'h0);
      step(1'b0, 36'h0, 1'b1, 36'h6);
      check_eq("mm_err", 64'(err), 64'h1);
      check_eq("mm_code", 64'(err_code), 64'h1);
      check_eq("mm_da", 64'(err_data_a), 64'h5);
      check_eq("mm_db", 64'(err_data_b), 64'h6);
      step(1'b1, 36'h9, 1'b1, 36'h9);
      step(1'b1, 36'hC, 1'b1, 36'hD);
      check_eq("mm_frz_match", 64'(match_count), 64'd6);
      check_eq("mm_frz_code", 64'(err_code), 64'h1);
      check_eq("mm_frz_da", 64'(err_data_a), 64'h5);
      check_eq("mm_frz_db", 64'(err_data_b), 64'h6);
      pulse_reset();
      check_all_zero("rst2");

      // Overflow: five A pushes with B idle
      for (int i = 0; i < 4; i++) step(1'b1, 36'h11 + 36'(i), 1'b0, 36'h0);
      check_eq("of_pend4", 64'(pending), 64'd4);
      check_eq("of_noerr", 64'(err), 64'h0);
      step(1'b1, 36'h15, 1'b0, 36'h0);
      check_eq("of_err", 64'(err), 64'h1);
      check_eq("of_code", 64'(err_code), 64'h2);
      check_eq("of_pend", 64'(pending), 64'd4);
      check_eq("of_da", 64'(err_data_a), 64'h11);
      check_eq("of_db", 64'(err_data_b), 64'h15);
      pulse_reset();

      // Timeout: one A item, B idle, error exactly 8 cycles after the push
      step(1'b1, 36'h21, 1'b0, 36'h0);
      idle(7);
      check_eq("to_not_yet", 64'(err), 64'h0);
      idle(1);
      check_eq("to_err", 64'(err), 64'h1);
      check_eq("to_code", 64'(err_code), 64'h3);
      pulse_reset();

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) step(1'b1, 36'h31 + 36'(i), 1'b0, 36'h0);
      check_eq("fp_pend_full", 64'(pending), 64'd4);
      step(1'b1, 36'h35, 1'b1, 36'h31);
      check_eq("fp_pend", 64'(pending), 64'd4);
      check_eq("fp_err", 64'(err), 64'h0);
      check_eq("fp_match", 64'(match_count), 64'd1);
      check_eq("fp_lead", 64'(lead), 64'h1);
      step(1'b0, 36'h0, 1'b1, 36'h32);
      check_eq("fp_pend3", 64'(pending), 64'd3);
      check_eq("fp_match2", 64'(match_count), 64'd2);

      // Mid-operation reset discards buffered items
      resetn = 1'b0;
      idle(1);
      check_all_zero("midrst");
      resetn = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
